// File: rtl/commit_writeback_pkg.sv
// Shared types for commit_writeback: destination kinds, FSM states, GPR indices and
// the latched commit request record.
package commit_writeback_pkg;

  typedef enum logic [1:0] {
    OPND_DEST_NONE     = 2'b00,
    OPND_DEST_REG_1HOT = 2'b01,
    OPND_DEST_MEM_1HOT = 2'b10,
    OPND_DEST_INVALID  = 2'b11
  } opnd_dest_e;

  typedef enum logic [1:0] {
    CWB_IDLE = 2'd0,
    CWB_WB0  = 2'd1,
    CWB_WB1  = 2'd2,
    CWB_FIN  = 2'd3
  } cwb_state_e;

  localparam logic [2:0] REG_EAX = 3'd0;
  localparam logic [2:0] REG_ECX = 3'd1;
  localparam logic [2:0] REG_EDX = 3'd2;
  localparam logic [2:0] REG_EBX = 3'd3;
  localparam logic [2:0] REG_ESP = 3'd4;
  localparam logic [2:0] REG_EBP = 3'd5;
  localparam logic [2:0] REG_ESI = 3'd6;
  localparam logic [2:0] REG_EDI = 3'd7;

  typedef struct packed {
    opnd_dest_e  kind;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] result;
  } dest_t;

  typedef struct packed {
    logic        is_write;
    logic [31:0] address;
    logic [31:0] data;
  } hint_t;

  typedef struct packed {
    dest_t       dest0;
    dest_t       dest1;
    logic        reg_1byte;
    logic        opnd16;
    logic [31:0] next_eip;
    hint_t       hint_pri;
    hint_t       hint_sec;
  } commit_req_t;

  // 8-bit size takes precedence over the 16-bit prefix.
  function automatic logic [31:0] width_mask(input logic reg_1byte, input logic opnd16);
    if (reg_1byte)   return 32'h0000_00FF;
    else if (opnd16) return 32'h0000_FFFF;
    else             return 32'hFFFF_FFFF;
  endfunction

  function automatic logic hint_ok(input hint_t h, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [31:0] mask);
    return h.is_write && (h.address == addr) && ((h.data & mask) == (data & mask));
  endfunction

endpackage

// File: rtl/commit_writeback_if.sv
// Commit request bus from execute into commit_writeback: destinations, results,
// operand size, next EIP and the two prover write hints.
interface commit_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  dest0_kind;
  logic [1:0]  dest1_kind;
  logic [31:0] dest0_sel;
  logic [31:0] dest1_sel;
  logic [31:0] dest0_addr;
  logic [31:0] dest1_addr;
  logic [31:0] result0;
  logic [31:0] result1;
  logic        reg_1byte;
  logic        prefix_operand_16bit;
  logic [31:0] next_eip;
  logic        hint1_is_write;
  logic [31:0] hint1_address;
  logic [31:0] hint1_data;
  logic        hint2_is_write;
  logic [31:0] hint2_address;
  logic [31:0] hint2_data;

  modport master (
    output in_valid, dest0_kind, dest1_kind, dest0_sel, dest1_sel, dest0_addr, dest1_addr,
           result0, result1, reg_1byte, prefix_operand_16bit, next_eip,
           hint1_is_write, hint1_address, hint1_data,
           hint2_is_write, hint2_address, hint2_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, dest0_kind, dest1_kind, dest0_sel, dest1_sel, dest0_addr, dest1_addr,
           result0, result1, reg_1byte, prefix_operand_16bit, next_eip,
           hint1_is_write, hint1_address, hint1_data,
           hint2_is_write, hint2_address, hint2_data,
    output in_ready
  );
endinterface

// File: rtl/reg_merge.sv
// Merges a write result into an old GPR value according to operand size
// (32-bit, 16-bit, low byte or high byte AH..BH).
module reg_merge (
  input  logic [31:0] old_val,
  input  logic [31:0] new_val,
  input  logic [2:0]  sel,
  input  logic        reg_1byte,
  input  logic        opnd16,
  output logic [31:0] merged
);

  logic unused_sel_lo;
  assign unused_sel_lo = ^sel[1:0];

  always_comb begin
    merged = new_val;
    if (reg_1byte) begin
      // sel 4..7 in byte mode addresses AH/CH/DH/BH, i.e. bits [15:8] of the caller's row.
      if (sel[2]) merged = {old_val[31:16], new_val[7:0], old_val[7:0]};
      else        merged = {old_val[31:8], new_val[7:0]};
    end else if (opnd16) begin
      merged = {old_val[31:16], new_val[15:0]};
    end
  end

endmodule

// File: rtl/commit_writeback.sv
// Retires one executed instruction: writes register destinations into the GPR file,
// checks memory destinations against prover write hints, then advances EIP and pulses done.
module commit_writeback
  import commit_writeback_pkg::*;
#(
  parameter logic [31:0] RESET_EIP            = 32'h0,
  parameter bit          FAULT_ON_UNUSED_HINT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  commit_writeback_if.slave  cmt,
  output logic [31:0]        eax,
  output logic [31:0]        ecx,
  output logic [31:0]        edx,
  output logic [31:0]        ebx,
  output logic [31:0]        esp,
  output logic [31:0]        ebp,
  output logic [31:0]        esi,
  output logic [31:0]        edi,
  output logic [31:0]        eip,
  output logic               done,
  output logic               fault
);

  cwb_state_e  state_q, state_d;
  commit_req_t req_q, req_d;
  commit_req_t new_req;
  logic [31:0] gpr_q [8];
  logic [31:0] gpr_d [8];
  logic [31:0] eip_q, eip_d;
  logic        fault_q, fault_d;
  logic        dest0_mem_q, dest0_mem_d;
  logic        pri_hint_used_q, pri_hint_used_d;
  logic        sec_hint_used_q, sec_hint_used_d;

  dest_t       cur;
  hint_t       cur_hint;
  logic        use_sec;
  logic [2:0]  wr_idx;
  logic [31:0] mask;
  logic [31:0] merged;

  logic unused_sel_hi;
  assign unused_sel_hi = ^{cmt.dest0_sel[31:3], cmt.dest1_sel[31:3]};

  always_comb begin
    new_req                   = '0;
    new_req.dest0.kind        = opnd_dest_e'(cmt.dest0_kind);
    new_req.dest0.sel         = cmt.dest0_sel[2:0];
    new_req.dest0.addr        = cmt.dest0_addr;
    new_req.dest0.result      = cmt.result0;
    new_req.dest1.kind        = opnd_dest_e'(cmt.dest1_kind);
    new_req.dest1.sel         = cmt.dest1_sel[2:0];
    new_req.dest1.addr        = cmt.dest1_addr;
    new_req.dest1.result      = cmt.result1;
    new_req.reg_1byte         = cmt.reg_1byte;
    new_req.opnd16            = cmt.prefix_operand_16bit;
    new_req.next_eip          = cmt.next_eip;
    new_req.hint_pri.is_write = cmt.hint1_is_write;
    new_req.hint_pri.address  = cmt.hint1_address;
    new_req.hint_pri.data     = cmt.hint1_data;
    new_req.hint_sec.is_write = cmt.hint2_is_write;
    new_req.hint_sec.address  = cmt.hint2_address;
    new_req.hint_sec.data     = cmt.hint2_data;
  end

  // One merge/check datapath shared by WB0 and WB1 via the latched destination mux.
  always_comb begin
    cur      = (state_q == CWB_WB1) ? req_q.dest1 : req_q.dest0;
    use_sec  = (state_q == CWB_WB1) && dest0_mem_q;
    cur_hint = use_sec ? req_q.hint_sec : req_q.hint_pri;
    mask     = width_mask(req_q.reg_1byte, req_q.opnd16);
    wr_idx   = (req_q.reg_1byte && cur.sel[2]) ? {1'b0, cur.sel[1:0]} : cur.sel;
  end

  reg_merge u_reg_merge (
    .old_val   (gpr_q[wr_idx]),
    .new_val   (cur.result),
    .sel       (cur.sel),
    .reg_1byte (req_q.reg_1byte),
    .opnd16    (req_q.opnd16),
    .merged    (merged)
  );

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    gpr_d           = gpr_q;
    eip_d           = eip_q;
    fault_d         = fault_q;
    dest0_mem_d     = dest0_mem_q;
    pri_hint_used_d = pri_hint_used_q;
    sec_hint_used_d = sec_hint_used_q;
    case (state_q)
      CWB_IDLE: begin
        if (cmt.in_valid) begin
          req_d           = new_req;
          dest0_mem_d     = 1'b0;
          pri_hint_used_d = 1'b0;
          sec_hint_used_d = 1'b0;
          state_d         = CWB_WB0;
        end
      end
      CWB_WB0, CWB_WB1: begin
        case (cur.kind)
          OPND_DEST_REG_1HOT: begin
            if (!fault_q) gpr_d[wr_idx] = merged;
          end
          OPND_DEST_MEM_1HOT: begin
            if (!hint_ok(cur_hint, cur.addr, cur.result, mask)) fault_d = 1'b1;
            if (use_sec) sec_hint_used_d = 1'b1;
            else         pri_hint_used_d = 1'b1;
            if (state_q == CWB_WB0) dest0_mem_d = 1'b1;
          end
          OPND_DEST_INVALID: fault_d = 1'b1;
          default: ;
        endcase
        state_d = (state_q == CWB_WB0) ? CWB_WB1 : CWB_FIN;
      end
      CWB_FIN: begin
        if (FAULT_ON_UNUSED_HINT &&
            ((req_q.hint_pri.is_write && !pri_hint_used_q) ||
             (req_q.hint_sec.is_write && !sec_hint_used_q)))
          fault_d = 1'b1;
        // An unused-hint fault detected here also blocks this commit's EIP update.
        if (!fault_d) eip_d = req_q.next_eip;
        state_d = CWB_IDLE;
      end
      default: state_d = CWB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= CWB_IDLE;
      req_q           <= '0;
      for (int unsigned i = 0; i < 8; i++) gpr_q[i] <= '0;
      eip_q           <= RESET_EIP;
      fault_q         <= 1'b0;
      dest0_mem_q     <= 1'b0;
      pri_hint_used_q <= 1'b0;
      sec_hint_used_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      gpr_q           <= gpr_d;
      eip_q           <= eip_d;
      fault_q         <= fault_d;
      dest0_mem_q     <= dest0_mem_d;
      pri_hint_used_q <= pri_hint_used_d;
      sec_hint_used_q <= sec_hint_used_d;
    end
  end

  assign cmt.in_ready = (state_q == CWB_IDLE);
  assign done         = (state_q == CWB_FIN);
  assign fault        = fault_q;
  assign eip          = eip_q;
  assign eax          = gpr_q[REG_EAX];
  assign ecx          = gpr_q[REG_ECX];
  assign edx          = gpr_q[REG_EDX];
  assign ebx          = gpr_q[REG_EBX];
  assign esp          = gpr_q[REG_ESP];
  assign ebp          = gpr_q[REG_EBP];
  assign esi          = gpr_q[REG_ESI];
  assign edi          = gpr_q[REG_EDI];

endmodule
